// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster constants and total-length helpers
package vga_timing_pkg;

   localparam int COORD_BITS   = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int h_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_raster_counter.sv
// raster_counter: modulo-(MAX+1) counter advancing on inc_i, flagging the wrap step
module raster_counter
   import vga_timing_pkg::*;
#(
   parameter int WIDTH = COORD_BITS,
   parameter int MAX   = 799
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign wrap_o = inc_i && (cnt_q == LAST);
   assign cnt_o  = cnt_q;

   // advance on inc, return to zero on the terminal count
   always_comb cnt_d = inc_i ? (wrap_o ? '0 : cnt_q + 1'b1) : cnt_q;

   // count register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel strobe, raster counters, sync flags and holdable frame counter
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int FRAME_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold,
   input  logic                  step,
   output logic                  enable,
   output logic [COORD_BITS-1:0] x,
   output logic [COORD_BITS-1:0] y,
   output logic                  active,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  new_frame,
   output logic [FRAME_BITS-1:0] frame_cnt
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [COORD_BITS-1:0] H_ACT_END = COORD_BITS'(H_ACTIVE);
   localparam logic [COORD_BITS-1:0] HS_START  = COORD_BITS'(H_ACTIVE + H_FP);
   localparam logic [COORD_BITS-1:0] HS_END    = COORD_BITS'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_BITS-1:0] V_ACT_END = COORD_BITS'(V_ACTIVE);
   localparam logic [COORD_BITS-1:0] VS_START  = COORD_BITS'(V_ACTIVE + V_FP);
   localparam logic [COORD_BITS-1:0] VS_END    = COORD_BITS'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [1:0]            DIV_LAST  = 2'(CLK_DIV - 1);

   logic [1:0]            div_cnt_q, div_cnt_d;
   logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
   logic                  step_pending_q, step_pending_d;
   logic                  h_wrap, v_wrap;

   // with CLK_DIV=1 the divider never leaves 0, so enable is constant 1
   assign enable = (div_cnt_q == DIV_LAST);

   raster_counter #(.WIDTH(COORD_BITS), .MAX(H_TOTAL - 1)) u_h_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (enable),
      .cnt_o  (x),
      .wrap_o (h_wrap)
   );

   raster_counter #(.WIDTH(COORD_BITS), .MAX(V_TOTAL - 1)) u_v_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (h_wrap),
      .cnt_o  (y),
      .wrap_o (v_wrap)
   );

   // flags decode the live counters so they never skew against x/y
   assign active    = (x < H_ACT_END) && (y < V_ACT_END);
   assign hsync     = (x >= HS_START) && (x < HS_END);
   assign vsync     = (y >= VS_START) && (y < VS_END);
   assign new_frame = enable && (x == '0) && (y == '0);
   assign frame_cnt = frame_cnt_q;

   // divider wrap, frame advance on the frame wrap, and step latching between wraps
   always_comb begin
      div_cnt_d      = enable ? 2'd0 : div_cnt_q + 2'd1;
      frame_cnt_d    = (v_wrap && (!hold || step_pending_q || step)) ? frame_cnt_q + 1'b1 : frame_cnt_q;
      step_pending_d = v_wrap ? 1'b0 : (step_pending_q | step);
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         div_cnt_q      <= '0;
         frame_cnt_q    <= '0;
         step_pending_q <= 1'b0;
      end else begin
         div_cnt_q      <= div_cnt_d;
         frame_cnt_q    <= frame_cnt_d;
         step_pending_q <= step_pending_d;
      end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized hold/step stimulus against an arithmetic raster model
module tb_vga_timing_gen;

   localparam int CD = 2;
   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 6, VF = 1, VS = 2, VB = 1;
   localparam int FB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT * CD;

   logic          clk, rst_n, hold, step;
   logic          enable, active, hsync, vsync, new_frame;
   logic [9:0]    x, y;
   logic [FB-1:0] frame_cnt;

   int checks = 0, errors = 0;
   int e = 0, c = 0, fm = 0, pend = 0;

   vga_timing_gen #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FRAME_BITS(FB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .step(step), .enable(enable),
      .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
      .new_frame(new_frame), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit en_now();
      return (c % CD) == CD - 1;
   endfunction

   function automatic bit wrap_now();
      return en_now() && (e % HT == HT - 1) && ((e / HT) % VT == VT - 1);
   endfunction

   task automatic check_all();
      int ex, ey;
      ex = e % HT;
      ey = (e / HT) % VT;
      chk("enable",    32'(enable),    32'(en_now()));
      chk("x",         32'(x),         ex);
      chk("y",         32'(y),         ey);
      chk("active",    32'(active),    32'(ex < HA && ey < VA));
      chk("hsync",     32'(hsync),     32'(ex >= HA + HF && ex < HA + HF + HS));
      chk("vsync",     32'(vsync),     32'(ey >= VA + VF && ey < VA + VF + VS));
      chk("new_frame", 32'(new_frame), 32'(en_now() && ex == 0 && ey == 0));
      chk("frame_cnt", 32'(frame_cnt), fm);
   endtask

   task automatic model_reset();
      e = 0; c = 0; fm = 0; pend = 0;
   endtask

   task automatic cyc(input logic h, input logic s);
      bit w, en;
      hold = h;
      step = s;
      check_all();
      @(posedge clk);
      if (rst_n) begin
         w  = wrap_now();
         en = en_now();
         if (w) begin
            if (!h || pend != 0 || s) fm = (fm + 1) % (1 << FB);
            pend = 0;
         end else if (s) pend = 1;
         if (en) e++;
         c++;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic h);
      repeat (n) cyc(h, 1'b0);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; hold = 1'b0; step = 1'b0;
      @(negedge clk);
      run(3, 1'b0);
      rst_n = 1'b1;
      run(FR + FR / 3, 1'b0);
      run(3 * FR, 1'b1);
      run(37, 1'b1);
      cyc(1'b1, 1'b1);
      run(2 * FR, 1'b1);
      run(51, 1'b1);
      cyc(1'b1, 1'b1);
      run(23, 1'b1);
      cyc(1'b1, 1'b1);
      run(2 * FR, 1'b1);
      guard = 0;
      while (!wrap_now() && guard < 2 * FR) begin
         cyc(1'b1, 1'b0);
         guard++;
      end
      chk("wrap_reached", 32'(wrap_now()), 32'd1);
      cyc(1'b1, 1'b1);
      run(2 * FR, 1'b1);
      for (int i = 0; i < 3 * FR; i++) cyc(1'b1, 1'($urandom_range(0, 60) == 0));
      for (int i = 0; i < 4 * FR; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 30) == 0));
      run(FR / 2 + 17, 1'b0);
      #2 rst_n = 1'b0;
      #1 model_reset();
      chk("async_x",     32'(x),         32'd0);
      chk("async_y",     32'(y),         32'd0);
      chk("async_frame", 32'(frame_cnt), 32'd0);
      @(negedge clk);
      run(2, 1'b0);
      rst_n = 1'b1;
      run(17 * FR + 5, 1'b0);
      chk("frame_wrapped", 32'(frame_cnt), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream timing source for the demo top level.
- Divides clk into a pixel-enable strobe and runs horizontal/vertical raster counters.
- Outputs active-high hsync/vsync, active-video flag, pixel coordinates, a new_frame strobe, and a frame counter.
- Frame counter supports hold/single-step so the renderer can freeze on one frame and advance it manually.

Parameters:
- CLK_DIV, 2, clk cycles per pixel; legal values 1..4.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- FRAME_BITS, 8, frame counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- hold  in  1  1 = freeze frame_cnt except for steps.
- step  in  1  single-cycle pulse; requests one frame_cnt increment while hold=1.
- enable  out  1  pixel strobe, one clk cycle wide, every CLK_DIV cycles.
- x  out  10  horizontal counter, 0..H_TOTAL-1.
- y  out  10  vertical counter, 0..V_TOTAL-1.
- active  out  1  (x<H_ACTIVE)&&(y<V_ACTIVE).
- hsync  out  1  active high; pads invert.
- vsync  out  1  active high; pads invert.
- new_frame  out  1  one-clk pulse at pixel (0,0).
- frame_cnt  out  FRAME_BITS  frame number.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state clears immediately on rst_n low, with no dependence on clk.
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values: div_cnt=0, x=0, y=0, frame_cnt=0, step_pending=0, active=1, hsync=0, vsync=0.
  - enable = (div_cnt==CLK_DIV-1). For CLK_DIV=1 it is constant 1, including during reset.
  - new_frame = enable && x==0 && y==0.
- Divider: div_cnt increments each clk and wraps CLK_DIV-1→0. With CLK_DIV=2, enable is 0 in the first cycle after reset release, then alternates 1,0,...
- Horizontal counter: on an edge with enable=1, x increments; at H_TOTAL-1 it wraps to 0. Without enable, x holds.
- Vertical counter: y increments only on an edge where enable=1 and x==H_TOTAL-1; at V_TOTAL-1 it wraps to 0.
- Flags are pure functions of the current x,y with zero-cycle skew against x,y. They may be registered alongside the counters, provided they stay aligned.
  - hsync=1 when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync=1 when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
- Frame wrap event: the enable edge where x==H_TOTAL-1 and y==V_TOTAL-1.
- frame_cnt at wrap: increments when (!hold || step_pending || step). It wraps modulo 2^FRAME_BITS (255→0).
- step_pending:
  - Set on any clk edge with step=1 that is not a wrap event.
  - Cleared on every wrap event, whether or not it was used.
  - step coincident with the wrap counts for that wrap.
  - Multiple steps within one frame give one increment.
- hold changes take effect at the next wrap evaluation; no retiming.
- Reset mid-frame: immediate return to (0,0). The first enable after release produces new_frame.

Decomposition:
- Shared package vga_timing_pkg:
  - default porch/sync constants and the H_TOTAL/V_TOTAL derivation functions;
  - coordinate width constant COORD_BITS=10.
- One sub-module, raster_counter: a wrap counter with inc/wrap outputs and parameterized max. Instantiated twice, horizontal and vertical; the horizontal wrap output chains into the vertical inc.
- Divider and frame/step logic live in the top of this block.

Test Plan:
- Release rst_n, CLK_DIV=2 -> enable low in the first cycle after release, then toggles. new_frame is high on the first enable cycle with x=0,y=0, and never again until 800*525 enables later.
- Run one line -> hsync rises when x becomes 656, falls at x=752. active drops at x=640. x wraps 799→0 and y increments 0→1 on that same edge.
- Run one frame -> vsync high exactly for y=490,491 (1600 enables). active low for y>=480. frame_cnt goes 0→1 at the wrap edge.
- hold=1, no step, 3 frames -> frame_cnt stays at 1. One step pulse mid-frame, then 2 frames -> frame_cnt=2 after the next wrap only. Two steps in one frame -> +1 only.
- hold=1, step asserted on the exact wrap edge -> increments at that wrap, and step_pending is 0 afterwards.
- Assert rst_n low asynchronously at x=300,y=200 between clk edges -> x,y,frame_cnt read 0 before the next clk edge. Run 256 frames with hold=0 -> frame_cnt wraps 255→0.
